// File: rtl/rns_241_256_to_bin_pkg.sv
// Shared constants, stage payload type and residue helper for the (241,256) RNS-to-binary converter.
package rns_241_256_to_bin_pkg;

    localparam int MOD_A       = 241;
    localparam int MOD_B       = 256;
    localparam int INV_B_MOD_A = 225;
    localparam int RES_W       = 8;
    localparam int X_W         = 16;

    // res carries d in stage 1 and t in stage 2; r256 rides along unreduced
    typedef struct packed {
        logic [RES_W-1:0] r256;
        logic [RES_W-1:0] res;
    } stage_t;

    function automatic logic [RES_W-1:0] canon241(input logic [RES_W-1:0] r);
        return (r >= RES_W'(MOD_A)) ? r - RES_W'(MOD_A) : r;
    endfunction

endpackage

// File: rtl/rns_241_256_to_bin_mod_241_reduce16.sv
// Combinational 16-bit to 0..240 reduction: two folds using 256 = 15 (mod 241), then one conditional subtract.
module mod_241_reduce16
    import rns_241_256_to_bin_pkg::*;
(
    input  logic [15:0]      val_i,
    output logic [RES_W-1:0] res_o
);

    logic [11:0] fold1;
    logic [8:0]  fold2;

    // fold1 <= 255*15+255 = 4080; fold2 <= 15*15+255 = 480 < 2*241
    always_comb begin
        fold1 = 12'(val_i[15:8]) * 12'd15 + 12'(val_i[7:0]);
        fold2 = 9'(fold1[11:8]) * 9'd15 + 9'(fold1[7:0]);
        res_o = (fold2 >= 9'(MOD_A)) ? RES_W'(fold2 - 9'(MOD_A)) : fold2[RES_W-1:0];
    end

endmodule

// File: rtl/rns_241_256_to_bin.sv
// CRT reconstruction x = r256 + 256*((r241-r256)*225 mod 241); 3-stage pipeline, 3-cycle latency,
// one pair per cycle; each stage holds under out_ready backpressure, in_ready low while full or in reset.
module rns_241_256_to_bin
    import rns_241_256_to_bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] r241,
    input  logic [RES_W-1:0] r256,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   x
);

    logic             s1_vld_q, s2_vld_q, s3_vld_q;
    stage_t           s1_q, s1_d, s2_q, s2_d;
    logic [X_W-1:0]   x_q, x_d;
    logic             adv1, adv2, adv3;
    logic [RES_W-1:0] a_red, b_red, t_red;
    logic [15:0]      prod;

    assign adv3 = !s3_vld_q || out_ready;
    assign adv2 = !s2_vld_q || adv3;
    assign adv1 = !s1_vld_q || adv2;

    assign in_ready  = adv1 && !rst;
    assign out_valid = s3_vld_q;
    assign x         = x_q;

    // a-b+241 wraps correctly in 8 bits when a < b, landing in 1..240
    always_comb begin
        a_red      = canon241(r241);
        b_red      = canon241(r256);
        s1_d.r256  = r256;
        s1_d.res   = (a_red >= b_red) ? a_red - b_red : a_red - b_red + RES_W'(MOD_A);
    end

    assign prod = 16'(s1_q.res) * 16'(INV_B_MOD_A);

    mod_241_reduce16 u_reduce (
        .val_i (prod),
        .res_o (t_red)
    );

    always_comb begin
        s2_d.r256 = s1_q.r256;
        s2_d.res  = t_red;
        x_d       = {s2_q.res, s2_q.r256};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            x_q      <= '0;
        end else begin
            if (adv1) s1_vld_q <= in_valid;
            if (adv2) s2_vld_q <= s1_vld_q;
            if (adv3) s3_vld_q <= s2_vld_q;
            if (adv1 && in_valid) s1_q <= s1_d;
            if (adv2 && s1_vld_q) s2_q <= s2_d;
            if (adv3 && s2_vld_q) x_q  <= x_d;
        end
    end

endmodule

// File: tb/tb_rns_241_256_to_bin.sv
// Scoreboard bench: the driver queues expected x at acceptance, a negedge monitor pops and checks value, order, latency and hold.
module tb_rns_241_256_to_bin;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  r241;
    logic [7:0]  r256;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;

    rns_241_256_to_bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r241      (r241),
        .r256      (r256),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x)
    );

    typedef struct {
        logic [15:0] xv;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: output order/value, 3-cycle latency where flagged, and hold while stalled
    bit          prev_stall = 1'b0;
    logic [15:0] prev_x     = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check(out_valid === 1'b1, "hold_valid", int'(out_valid), 1);
                check(x === prev_x, "hold_x", int'(x), int'(prev_x));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_output", int'(x), -1);
                end else begin
                    e = sbq.pop_front();
                    check(x === e.xv, "x_value", int'(x), int'(e.xv));
                    if (e.lat) check(cyc - e.cyc == 3, "latency", cyc - e.cyc, 3);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_x     = x;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ex, input bit lat);
        bit acc = 1'b0;
        int w   = 0;
        in_valid = 1'b1;
        r241     = a;
        r256     = b;
        while (!acc && w < 50) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sbq.push_back('{xv: ex, cyc: cyc, lat: lat});
            end
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) check(1'b0, "accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(sbq.size() == 0, "drain", sbq.size(), 0);
    endtask

    // Stall pairs: hand-computed CRT results
    logic [7:0]  pa[5] = '{8'd0, 8'd1, 8'd36, 8'd240, 8'd4};
    logic [7:0]  pb[5] = '{8'd1, 8'd0, 8'd232, 8'd255, 8'd10};
    logic [15:0] px[5] = '{16'd4097, 16'd57600, 16'd1000, 16'd61695, 16'd24586};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int t0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        r241      = '0;
        r256      = '0;
        #1;
        check(out_valid === 1'b0, "reset_out_valid", int'(out_valid), 0);
        check(in_ready === 1'b0, "reset_in_ready", int'(in_ready), 0);
        check(x === 16'd0, "reset_x", int'(x), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(in_ready === 1'b1, "in_ready_after_reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Directed vectors; (245,10) aliases (4,10)
        send(8'd0,   8'd0,   16'd0,     1'b1);
        send(8'd36,  8'd232, 16'd1000,  1'b1);
        send(8'd240, 8'd255, 16'd61695, 1'b1);
        send(8'd4,   8'd10,  16'd24586, 1'b1);
        send(8'd245, 8'd10,  16'd24586, 1'b1);
        send(8'd1,   8'd0,   16'd57600, 1'b1);
        send(8'd0,   8'd1,   16'd4097,  1'b1);
        drain();

        // Backpressure: 6 stalled cycles with 5 pairs offered
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        r241      = pa[0];
        r256      = pb[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                sbq.push_back('{xv: px[idx], cyc: cyc, lat: 1'b0});
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 5) begin r241 = pa[idx]; r256 = pb[idx]; end
            else in_valid = 1'b0;
        end
        check(idx == 3, "stall_accepts", idx, 3);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check(out_valid === 1'b1, "no_gap", int'(out_valid), 1);
            if (in_valid && in_ready) begin
                sbq.push_back('{xv: px[idx], cyc: cyc, lat: 1'b0});
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 5) begin r241 = pa[idx]; r256 = pb[idx]; end
            else in_valid = 1'b0;
        end
        check(idx == 5, "stall_total_accepts", idx, 5);
        in_valid = 1'b0;
        drain();

        // Reset with two pairs in flight
        send(8'd36, 8'd232, 16'd1000, 1'b1);
        send(8'd1,  8'd0,   16'd57600, 1'b1);
        rst = 1'b1;
        #1;
        check(out_valid === 1'b0, "midrst_out_valid", int'(out_valid), 0);
        check(in_ready === 1'b0, "midrst_in_ready", int'(in_ready), 0);
        check(x === 16'd0, "midrst_x", int'(x), 0);
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(in_ready === 1'b1, "in_ready_after_midrst", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'd240, 8'd255, 16'd61695, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        drain();

        // Full sweep, back-to-back
        t0 = cyc;
        for (int v = 0; v < 61696; v++) begin
            send(8'(v % 241), 8'(v % 256), 16'(v), 1'b1);
        end
        check(cyc - t0 == 61696, "sweep_throughput", cyc - t0, 61696);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
